// File: rtl/icon_pkg.sv
// Shared constants and owner-tag type for the icon ROM arbiter.
// Address width depends on ICON_ORIENT_EN (8 orientation images when defined).
package icon_pkg;

  localparam int unsigned ICON_DIM  = 16;
  localparam int unsigned ICON_LOG2 = 4;
  localparam logic [11:0] TRANSPARENT = 12'h000;

`ifdef ICON_ORIENT_EN
  localparam int unsigned AW = 2 * ICON_LOG2 + 3;
`else
  localparam int unsigned AW = 2 * ICON_LOG2;
`endif

  typedef enum logic [1:0] {IDLE, VID_MISS, VID_HIT, HOST} ownerTag_t;

endpackage

// File: rtl/icon_hit_calc.sv
// Combinational 16x16 window test for one bot plus the relative icon address.
module icon_hit_calc
  import icon_pkg::*;
(
  input  logic                   vidValid,
  input  logic [9:0]             pixCol,
  input  logic [9:0]             pixRow,
  input  logic [7:0]             locX,
  input  logic [7:0]             locY,
  output logic                   hit,
  output logic [2*ICON_LOG2-1:0] relAddr
);

  logic [10:0] col11, row11, lx11, ly11;
  logic [ICON_LOG2-1:0] dCol, dRow;

  // 11-bit compare so loc+15 never wraps at loc=255
  assign col11 = {1'b0, pixCol};
  assign row11 = {1'b0, pixRow};
  assign lx11  = {3'b000, locX};
  assign ly11  = {3'b000, locY};

  assign hit = vidValid
             && (col11 >= lx11) && (col11 <= lx11 + 11'(ICON_DIM - 1))
             && (row11 >= ly11) && (row11 <= ly11 + 11'(ICON_DIM - 1));

  // Low bits of the difference only depend on the low bits of the operands
  assign dCol = pixCol[ICON_LOG2-1:0] - locX[ICON_LOG2-1:0];
  assign dRow = pixRow[ICON_LOG2-1:0] - locY[ICON_LOG2-1:0];
  assign relAddr = {dRow, dCol};

endmodule

// File: rtl/icon_rom_arbiter.sv
// Shares the icon ROM between the video pixel stream and a host read port.
// Define ICON_ORIENT_EN to select one of 8 icon images by the orient input.
module icon_rom_arbiter
  import icon_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_valid,
  input  logic [9:0]        pix_col,
  input  logic [9:0]        pix_row,
  input  logic [7:0]        loc_x,
  input  logic [7:0]        loc_y,
  input  logic [2:0]        orient,
  input  logic              host_req,
  input  logic [AW-1:0]     host_addr,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              rom_en,
  output logic [AW-1:0]     rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              icon_valid,
  output logic [DATA_W-1:0] icon_pix,
  output logic [7:0]        drop_cnt
);

  logic                   hit;
  logic [2*ICON_LOG2-1:0] relAddr;
  logic [AW-1:0]          vidAddr;
  logic                   starve, vidWin, drop;
  ownerTag_t              tagD, tag1Q, tag2Q;
  logic [3:0]             waitCntQ;
  logic [2:0]             vidDlyQ;
  logic                   romEnQ, hostRvalidQ;
  logic [AW-1:0]          romAddrQ;
  logic [DATA_W-1:0]      iconPixQ, hostRdataQ;
  logic [7:0]             dropCntQ;

  icon_hit_calc u_hit_calc (
    .vidValid (vid_valid),
    .pixCol   (pix_col),
    .pixRow   (pix_row),
    .locX     (loc_x),
    .locY     (loc_y),
    .hit      (hit),
    .relAddr  (relAddr)
  );

`ifdef ICON_ORIENT_EN
  assign vidAddr = {orient, relAddr};
`else
  logic unusedOrient;
  assign unusedOrient = ^orient;
  assign vidAddr = relAddr;
`endif

  assign starve   = host_req && (waitCntQ == 4'(STARVE_MAX));
  assign vidWin   = hit && !starve;
  assign drop     = hit && starve;
  assign host_gnt = reset && host_req && (starve || !hit);

  always_comb begin
    tagD = IDLE;
    if (vidWin)         tagD = VID_HIT;
    else if (host_gnt)  tagD = HOST;
    else if (vid_valid) tagD = VID_MISS;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCntQ    <= '0;
      romEnQ      <= 1'b0;
      romAddrQ    <= '0;
      tag1Q       <= IDLE;
      tag2Q       <= IDLE;
      vidDlyQ     <= '0;
      iconPixQ    <= '0;
      hostRvalidQ <= 1'b0;
      hostRdataQ  <= '0;
      dropCntQ    <= '0;
    end else begin
      waitCntQ <= (host_req && !host_gnt) ? waitCntQ + 4'd1 : 4'd0;
      romEnQ   <= vidWin || host_gnt;
      if (vidWin)        romAddrQ <= vidAddr;
      else if (host_gnt) romAddrQ <= host_addr;
      tag1Q   <= tagD;
      tag2Q   <= tag1Q;
      vidDlyQ <= {vidDlyQ[1:0], vid_valid};
      // Dropped pixels carry a HOST tag, so they fall through to transparent
      iconPixQ    <= (tag2Q == VID_HIT) ? rom_dout : DATA_W'(TRANSPARENT);
      hostRvalidQ <= (tag2Q == HOST);
      if (tag2Q == HOST) hostRdataQ <= rom_dout;
      if (drop && dropCntQ != 8'hFF) dropCntQ <= dropCntQ + 8'd1;
    end
  end

  assign rom_en      = romEnQ;
  assign rom_addr    = romAddrQ;
  assign icon_valid  = vidDlyQ[2];
  assign icon_pix    = iconPixQ;
  assign host_rvalid = hostRvalidQ;
  assign host_rdata  = hostRdataQ;
  assign drop_cnt    = dropCntQ;

endmodule

// File: doc/icon_rom_arbiter.md
# icon_rom_arbiter

Controller that owns the single icon pixel-map ROM and shares it between two requesters: the video pixel stream and a host read port. The video stream always wins unless the host has starved.
- **Video path:** each active-video pixel is tested against the bot's 16×16 window. On a hit the block issues the ROM address and returns the icon colour, aligned and registered. On a miss it returns transparent `0x000`.
- **Host path:** a req/gnt handshake used for icon readback and diagnostics. A starvation counter guarantees forward progress.

The block sits between the pixel-position generator/bot-location registers and the colourizer.

## Interface
Parameters:
- `DATA_W`, 12, ROM word / colour width
- `STARVE_MAX`, 15, host wait cycles before a forced grant (1..15)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `vid_valid`  in  1  pixel position valid (active video)
- `pix_col`  in  10  current pixel column
- `pix_row`  in  10  current pixel row
- `loc_x`  in  8  bot top-left column
- `loc_y`  in  8  bot top-left row
- `orient`  in  3  bot orientation (used only with `ICON_ORIENT_EN`)
- `host_req`  in  1  host read request; hold with stable address until granted
- `host_addr`  in  AW  host ROM address
- `host_gnt`  out  1  combinational; request accepted at the edge where `host_req & host_gnt`
- `host_rvalid`  out  1  one-cycle pulse, read data valid
- `host_rdata`  out  DATA_W  read data
- `rom_en`  out  1  ROM read enable
- `rom_addr`  out  AW  ROM address
- `rom_dout`  in  DATA_W  ROM data, one-cycle registered latency
- `icon_valid`  out  1  `vid_valid` delayed 3 cycles
- `icon_pix`  out  DATA_W  icon colour, `0x000` = transparent
- `drop_cnt`  out  8  saturating count of video hits displaced by a forced host grant

AW is 8 by default and 11 with `ICON_ORIENT_EN`.

## Operation
- **Hit test:** `hit = vid_valid & pix_col ≥ loc_x & pix_col ≤ loc_x+15 & pix_row ≥ loc_y & pix_row ≤ loc_y+15`.
  - Compare in 11-bit unsigned so `loc_x+15` never wraps (`loc_x=255` gives a window of 255..270).
- **Video address:** `{pix_row-loc_y, pix_col-loc_x}`, low 4 bits of each difference.
- **Starvation counter `wait_cnt` (4 bits):**
  - Increments each cycle `host_req & !host_gnt`.
  - Clears on grant or when `host_req` is low.
- **Arbitration, evaluated every cycle:**
  - `wait_cnt == STARVE_MAX` and `host_req`: host wins. A concurrent video hit is dropped; that pixel outputs `0x000`, and `drop_cnt` increments, saturating at 255.
  - Else video hit: video wins, `host_gnt=0`.
  - Else `host_req`: host wins.
  - Else idle, `rom_en=0`.
- **Pipeline:** each stage carries an owner tag (`VID_HIT`, `VID_MISS`, `HOST`, `IDLE`). The stage-3 tag selects whether to drive `icon_pix` or `host_rdata`/`host_rvalid`.
- **`host_rdata`:** holds its last value when `host_rvalid` is low.
- **Reset mid-operation:** all pipeline tags return to `IDLE`, in-flight data is discarded, and no `host_rvalid` is produced for a pending grant.

## Timing
- Reset values: `rom_en=0`, `rom_addr=0`, `icon_valid=0`, `icon_pix=0`, `host_rvalid=0`, `host_rdata=0`, `drop_cnt=0`, `wait_cnt=0`.
- `host_gnt` is combinational: 0 while reset is asserted and 0 whenever `host_req` is low.
- Video path, inputs sampled at edge k:
  - `rom_addr`/`rom_en` registered at k.
  - ROM data available after k+1.
  - `icon_pix`/`icon_valid` registered at k+2, i.e. 3-cycle latency, one pixel per cycle, no bubbles.
- Host path: granted at edge k gives `host_rvalid` high for one cycle after edge k+2. The same latency as video allows back-to-back grants, one per cycle.
- Worst-case host wait: `STARVE_MAX+1` cycles.

## Configuration
- `ICON_ORIENT_EN` defined:
  - AW = 11; video address is `{orient, row[3:0], col[3:0]}`, i.e. 8 icon images.
  - `orient` is registered with the pixel.
- `ICON_ORIENT_EN` undefined:
  - AW = 8; a single icon.
  - `orient` is present but ignored.

## Structure
- Shared package `icon_pkg`:
  - `ICON_DIM=16`, `ICON_LOG2=4`
  - `TRANSPARENT=12'h000`
  - owner-tag enum `{IDLE, VID_MISS, VID_HIT, HOST}`
  - `AW` derivation
- One sub-module `icon_hit_calc`: combinational window test plus relative address; reused by future multi-bot logic.

## Test plan
- **Window hit:** `loc=(10,20)`, scan row 20 with col 8..28, ROM word = address → `icon_pix` nonzero exactly for cols 10..25, 3 cycles later; col 26 gives `0x000`.
- **Host idle grant:** `vid_valid=0`, `host_req` with `addr=0x35` → `host_gnt` same cycle, `host_rvalid` with `host_rdata=0x035` 3 cycles later.
- **Starvation:** continuous video hits with `host_req` held → grant on cycle 16 (`STARVE_MAX=15`), that pixel = `0x000`, `drop_cnt=1`.
- **Window wrap:** `loc_x=255`, `pix_col=270` hits, `pix_col=271` misses, `pix_col=5` misses.
- **Reset mid-flight:** assert `reset=0` one cycle after a host grant → no `host_rvalid`, all outputs 0, `drop_cnt` cleared.
- **Orientation:** with `ICON_ORIENT_EN`, `orient=5`, pixel (row 3, col 7) of the icon → `rom_addr=11'h537`.
